// File: rtl/riscv_mem_arbiter.sv
// Round-robin N-port arbiter onto one memory port, with boot-loader priority and range-error responses.
// Latency: memory command one cycle after accept; response MEM_LATENCY+1 cycles after accept.
// Backpressure: mem_ready=0 holds off in-range accepts only; responses are never stalled.
module riscv_mem_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 11,
    parameter int MEM_LATENCY = 1,
    parameter logic [ADDR_W-1:0] ADDR_MIN = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 32'h0000_FFFF,
    localparam int STRB_W     = DATA_W / 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_accept,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_wdata,
    input  logic [NUM_PORTS*STRB_W-1:0]   req_wstrb,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag,
    output logic [NUM_PORTS-1:0]          resp_valid,
    output logic [DATA_W-1:0]             resp_data,
    output logic [TAG_W-1:0]              resp_tag,
    output logic                          resp_error,
    input  logic                          load_we,
    input  logic [ADDR_W-1:0]             load_addr,
    input  logic [DATA_W-1:0]             load_wdata,
    input  logic                          loading_done,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_wdata,
    output logic [STRB_W-1:0]             mem_wstrb,
    output logic                          mem_we,
    output logic                          mem_re,
    input  logic                          mem_ready,
    input  logic [DATA_W-1:0]             mem_rdata
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {ST_LOAD, ST_RUN} state_t;

    typedef struct packed {
        logic             vld;
        logic [PTR_W-1:0] port;
        logic [TAG_W-1:0] tag;
        logic             err;
        logic             wr;
    } resp_ent_t;

    state_t            state, state_nxt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gnt_idx;
    logic              gnt_vld;
    logic              accept;
    logic              below_min, above_max, oor;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic [STRB_W-1:0] gnt_wstrb;
    logic [TAG_W-1:0]  gnt_tag;
    resp_ent_t         pipe [0:MEM_LATENCY];
    resp_ent_t         head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_LOAD && loading_done) state_nxt = ST_RUN;
    end

    // Scan downward so the candidate closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        int               j;
        logic [PTR_W-1:0] cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        j       = 0;
        cand    = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NUM_PORTS) j = j - NUM_PORTS;
            cand = PTR_W'(j);
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign gnt_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
    assign gnt_wstrb = req_wstrb[gnt_idx*STRB_W +: STRB_W];
    assign gnt_tag   = req_tag[gnt_idx*TAG_W +: TAG_W];

    // Borrow out of a widened subtract gives the unsigned range test without constant-compare corners.
    assign below_min = 1'(({1'b0, gnt_addr} - {1'b0, ADDR_MIN}) >> ADDR_W);
    assign above_max = 1'(({1'b0, ADDR_MAX} - {1'b0, gnt_addr}) >> ADDR_W);
    assign oor       = below_min | above_max;

    always_comb begin
        accept     = (state == ST_RUN) && gnt_vld && (mem_ready || oor);
        req_accept = accept ? (NUM_PORTS'(1) << gnt_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            if (state == ST_LOAD) begin
                if (load_we) begin
                    mem_we    <= 1'b1;
                    mem_wstrb <= '1;
                    mem_addr  <= load_addr;
                    mem_wdata <= load_wdata;
                end
            end else if (accept) begin
                rr_ptr <= (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                if (!oor) begin
                    mem_addr  <= gnt_addr;
                    mem_wdata <= gnt_wdata;
                    mem_wstrb <= gnt_wstrb;
                    mem_we    <= |gnt_wstrb;
                    mem_re    <= ~|gnt_wstrb;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MEM_LATENCY; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= '{vld: accept, port: gnt_idx, tag: gnt_tag, err: oor, wr: |gnt_wstrb};
            for (int k = 1; k <= MEM_LATENCY; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign head       = pipe[MEM_LATENCY];
    assign resp_valid = head.vld ? (NUM_PORTS'(1) << head.port) : '0;
    assign resp_tag   = head.vld ? head.tag : '0;
    assign resp_error = head.vld & head.err;
    assign resp_data  = (head.vld && !head.err && !head.wr) ? mem_rdata : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: two ports, MEM_LATENCY=2, behavioural memory with read data = addr ^ 0x5A5A0000 (0x100 -> 0xDEADBEEF).
module tb_riscv_mem_arbiter;
    localparam int NP = 2, AW = 32, DW = 32, SW = 4, TW = 11, ML = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    req_valid, req_accept, resp_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_wdata;
    logic [NP*SW-1:0] req_wstrb;
    logic [NP*TW-1:0] req_tag;
    logic [DW-1:0]    resp_data, load_wdata, mem_wdata, mem_rdata;
    logic [TW-1:0]    resp_tag;
    logic             resp_error, load_we, loading_done, mem_we, mem_re, mem_ready;
    logic [AW-1:0]    load_addr, mem_addr;
    logic [SW-1:0]    mem_wstrb;
    logic [DW-1:0]    rd_q0 = '0, rd_q1 = '0;

    int total = 0, bad = 0;
    int we_cnt = 0, re_cnt = 0, resp_cnt = 0;
    int snap_re, snap_resp;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .MEM_LATENCY(ML),
        .ADDR_MIN(32'h0000_0000), .ADDR_MAX(32'h0000_FFFF)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_accept(req_accept), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_tag(resp_tag), .resp_error(resp_error),
        .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata), .loading_done(loading_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_we(mem_we), .mem_re(mem_re), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    // Memory returns data ML=2 cycles after the cycle mem_re is high.
    always @(posedge clk) begin
        rd_q0 <= mem_re ? (mem_addr ^ 32'h5A5A_0000 ^ ((mem_addr == 32'h100) ? 32'h84F7_BFEF : 32'h0)) : '0;
        rd_q1 <= rd_q0;
    end
    assign mem_rdata = rd_q1;

    always @(negedge clk) begin
        if (mem_we && mem_wstrb == 4'hF) we_cnt++;
        if (mem_re) re_cnt++;
        if (resp_valid != '0) resp_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, input logic [TW-1:0] t);
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
        req_wstrb[p*SW +: SW] = s;
        req_tag[p*TW +: TW]   = t;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0; req_tag = '0;
        load_we = 1'b0; load_addr = '0; load_wdata = '0; loading_done = 1'b0; mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_accept", req_accept, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_resp_valid", resp_valid, 0);
        @(negedge clk) rst_n = 1'b1;

        // Loader owns memory even with both ports requesting and mem_ready low.
        set_port(0, 32'h100, '0, 4'h0, 11'h1);
        set_port(1, 32'h104, '0, 4'h0, 11'h2);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_we = 1'b1; load_addr = 32'(4 * i); load_wdata = 32'hA000_0000 + 32'(i);
            #1 chk("load_accept", req_accept, 0);
        end
        @(negedge clk);
        load_we = 1'b0;
        #1;
        chk("load_last_addr", mem_addr, 32'hC);
        chk("load_last_wdata", mem_wdata, 32'hA000_0003);
        chk("load_strb", mem_wstrb, 4'hF);
        @(negedge clk);
        #1;
        chk("load_we_count", we_cnt, 4);
        chk("load_no_read", re_cnt, 0);
        chk("load_no_resp", resp_cnt, 0);

        @(negedge clk) begin loading_done = 1'b1; req_valid = '0; end
        @(negedge clk) loading_done = 1'b0;

        // Round robin from pointer 0.
        set_port(0, 32'h200, '0, 4'h0, 11'h10);
        set_port(1, 32'h204, '0, 4'h0, 11'h11);
        mem_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            logic [1:0] ea, ev;
            @(negedge clk);
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            #1;
            ea = (c < 4) ? ((c % 2) ? 2'b10 : 2'b01) : 2'b00;
            ev = (c >= 3 && c < 7) ? (((c - 3) % 2) ? 2'b10 : 2'b01) : 2'b00;
            chk("rr_accept", req_accept, ea);
            chk("rr_resp_valid", resp_valid, ev);
            if (ev == 2'b01) begin
                chk("rr_data_p0", resp_data, 32'h5A5A_0200);
                chk("rr_tag_p0", resp_tag, 11'h10);
            end else if (ev == 2'b10) begin
                chk("rr_data_p1", resp_data, 32'h5A5A_0204);
                chk("rr_tag_p1", resp_tag, 11'h11);
            end
        end

        // Read latency on port 1.
        set_port(1, 32'h100, '0, 4'h0, 11'h2A);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 2'b10 : 2'b00;
            #1;
            if (c == 0) chk("lat_accept", req_accept, 2'b10);
            if (c == 1) begin
                chk("lat_mem_re", mem_re, 1);
                chk("lat_mem_addr", mem_addr, 32'h100);
            end
            chk("lat_resp_valid", resp_valid, (c == 3) ? 2'b10 : 2'b00);
            if (c == 3) begin
                chk("lat_data", resp_data, 32'hDEAD_BEEF);
                chk("lat_tag", resp_tag, 11'h2A);
                chk("lat_err", resp_error, 0);
            end
        end

        // Out-of-range read is accepted without mem_ready and never reaches memory.
        set_port(0, 32'h0001_0000, '0, 4'h0, 11'h155);
        mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 2'b01 : 2'b00;
            #1;
            if (c == 0) chk("err_accept", req_accept, 2'b01);
            chk("err_mem_re", mem_re, 0);
            chk("err_resp_valid", resp_valid, (c == 3) ? 2'b01 : 2'b00);
            if (c == 3) begin
                chk("err_flag", resp_error, 1);
                chk("err_tag", resp_tag, 11'h155);
                chk("err_data", resp_data, 0);
            end
        end

        // Partial write on port 0; pointer sits at 1 and wraps to 0.
        set_port(0, 32'h300, 32'h1234_5678, 4'h3, 11'h7);
        mem_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 2'b01 : 2'b00;
            #1;
            if (c == 0) chk("wr_accept", req_accept, 2'b01);
            if (c == 1) begin
                chk("wr_mem_we", mem_we, 1);
                chk("wr_mem_re", mem_re, 0);
                chk("wr_strb", mem_wstrb, 4'h3);
                chk("wr_wdata", mem_wdata, 32'h1234_5678);
            end
            chk("wr_resp_valid", resp_valid, (c == 3) ? 2'b01 : 2'b00);
            if (c == 3) begin
                chk("wr_tag", resp_tag, 11'h7);
                chk("wr_data", resp_data, 0);
                chk("wr_err", resp_error, 0);
            end
        end

        // Stall with both ports valid while an earlier read drains, then reset mid-flight.
        set_port(0, 32'h200, '0, 4'h0, 11'h20);
        set_port(1, 32'h204, '0, 4'h0, 11'h33);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ready = (c == 0 || c == 4);
            req_valid = (c == 0) ? 2'b10 : 2'b11;
            #1;
            chk("stall_accept", req_accept, (c == 0) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00);
            chk("stall_resp_valid", resp_valid, (c == 3) ? 2'b10 : 2'b00);
            if (c == 3) begin
                chk("stall_tag", resp_tag, 11'h33);
                chk("stall_data", resp_data, 32'h5A5A_0204);
            end
        end
        @(negedge clk);
        #1 chk("pre_rst_mem_re", mem_re, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_re", mem_re, 0);
        chk("midrst_accept", req_accept, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        snap_re = re_cnt; snap_resp = resp_cnt;
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1 chk("post_rst_accept", req_accept, 0);
        end
        chk("post_rst_resp_count", resp_cnt - snap_resp, 0);
        chk("post_rst_re_count", re_cnt - snap_re, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
